// File: rtl/dpc_stream_kernel.sv
// Streaming defective-pixel correction. Pixels listed in a raster-ordered LUT are
// replaced using their 3x3 neighbourhood, which is built from two line buffers.
module dpc_stream_kernel #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 11,
    parameter int MAX_COL   = 1024,
    parameter int MAX_BAD   = 128,
    parameter int BAD_BITS  = 7
) (
    input  logic                   axis_aclk,
    input  logic                   reset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [WIDTH-1:0]       s_axis_tdata,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic [CNT_WIDTH-1:0]   cfg_width,
    input  logic [CNT_WIDTH-1:0]   cfg_height,
    input  logic                   go,
    input  logic                   bypass,
    input  logic [BAD_BITS:0]      bad_point_num,
    input  logic                   lut_wen,
    input  logic [BAD_BITS-1:0]    lut_waddr,
    input  logic [2*CNT_WIDTH-1:0] lut_wdata,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            corrected_cnt,
    output logic                   sof_error
);
    localparam int COL_AW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
    typedef logic [WIDTH:0] pix_t;   // {bad flag, pixel}

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   width_q, width_d, height_q, height_d;
    logic                   bypass_q, bypass_d;
    logic [BAD_BITS:0]      bpn_q, bpn_d, ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   row_q, row_d, col_q, col_d;
    logic [CNT_WIDTH-1:0]   orow_q, orow_d, ocol_q, ocol_d, drain_q, drain_d;
    pix_t                   c_top_q, c_top_d, c_mid_q, c_mid_d, c_bot_q, c_bot_d;
    pix_t                   l_mid_q, l_mid_d;
    logic                   m_valid_q, m_valid_d, m_user_q, m_user_d, m_last_q, m_last_d;
    logic [WIDTH-1:0]       m_data_q, m_data_d;
    logic                   frame_done_q, frame_done_d, sof_err_q, sof_err_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [2*CNT_WIDTH-1:0] lut_mem [MAX_BAD];
    pix_t                   lb1_mem [MAX_COL];
    pix_t                   lb2_mem [MAX_COL];
    logic [2*CNT_WIDTH-1:0] lut_rd_q;
    pix_t                   lb1_rd_q, lb2_rd_q;

    logic adv, accept, drain_step, shift, fire, last_drain, start, lut_hit;
    logic l_ok, r_ok, u_ok, d_ok;
    logic [WIDTH:0]   sum_lr, sum_ud;
    logic [WIDTH-1:0] fixed, pix_out;
    pix_t             new_pix;
    logic             unused_tlast;

    assign unused_tlast  = s_axis_tlast;
    assign adv           = ~m_valid_q | m_axis_tready;
    assign s_axis_tready = adv & ((state_q == FILL) | (state_q == RUN));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign drain_step    = (state_q == DRAIN) & adv;
    assign shift         = accept | drain_step;
    assign fire          = (accept & (state_q == RUN)) | drain_step;
    assign last_drain    = drain_step & (drain_q == width_q);
    assign start         = ((state_q == IDLE) & go) | (last_drain & go);

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign corrected_cnt = cnt_q;
    assign sof_error     = sof_err_q;

    // Window before the shift: c_* is the centre column, l_mid its left, lb1_rd_q its right.
    always_comb begin
        lut_hit = (ptr_q < bpn_q) && (lut_rd_q == {row_q, col_q});
        new_pix = accept ? {lut_hit, s_axis_tdata} : '0;
        l_ok    = (ocol_q != '0) && !l_mid_q[WIDTH];
        r_ok    = (ocol_q != width_q - ONE) && !lb1_rd_q[WIDTH];
        u_ok    = (orow_q != '0) && !c_top_q[WIDTH];
        d_ok    = (orow_q != height_q - ONE) && !c_bot_q[WIDTH];
        sum_lr  = {1'b0, l_mid_q[WIDTH-1:0]} + {1'b0, lb1_rd_q[WIDTH-1:0]};
        sum_ud  = {1'b0, c_top_q[WIDTH-1:0]} + {1'b0, c_bot_q[WIDTH-1:0]};
        if (l_ok && r_ok)      fixed = sum_lr[WIDTH:1];
        else if (u_ok && d_ok) fixed = sum_ud[WIDTH:1];
        else if (l_ok)         fixed = l_mid_q[WIDTH-1:0];
        else if (r_ok)         fixed = lb1_rd_q[WIDTH-1:0];
        else if (u_ok)         fixed = c_top_q[WIDTH-1:0];
        else if (d_ok)         fixed = c_bot_q[WIDTH-1:0];
        else                   fixed = c_mid_q[WIDTH-1:0];
        pix_out = (c_mid_q[WIDTH] && !bypass_q) ? fixed : c_mid_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;   width_d = width_q;   height_d = height_q;
        bypass_d = bypass_q; bpn_d = bpn_q;       ptr_d = ptr_q;
        row_d = row_q;       col_d = col_q;       orow_d = orow_q;
        ocol_d = ocol_q;     drain_d = drain_q;
        c_top_d = c_top_q;   c_mid_d = c_mid_q;   c_bot_d = c_bot_q;   l_mid_d = l_mid_q;
        m_valid_d = m_valid_q; m_data_d = m_data_q; m_user_d = m_user_q; m_last_d = m_last_q;
        frame_done_d = 1'b0; sof_err_d = sof_err_q; cnt_d = cnt_q;

        if (shift) begin
            if (col_q == width_q - ONE) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
            c_top_d = lb2_rd_q;
            c_mid_d = lb1_rd_q;
            c_bot_d = new_pix;
            l_mid_d = c_mid_q;
        end
        if (accept && lut_hit) ptr_d = ptr_q + 1'b1;
        if (accept && s_axis_tuser && (row_q != '0 || col_q != '0)) sof_err_d = 1'b1;

        if (fire) begin
            m_valid_d = 1'b1;
            m_data_d  = pix_out;
            m_user_d  = (orow_q == '0) && (ocol_q == '0);
            m_last_d  = (ocol_q == width_q - ONE);
            if (ocol_q == width_q - ONE) begin
                ocol_d = '0;
                orow_d = orow_q + ONE;
            end else begin
                ocol_d = ocol_q + ONE;
            end
            if (c_mid_q[WIDTH] && !bypass_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else if (adv) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = '0;
                ptr_d = '0;
            end
            FILL:  if (accept && row_q == ONE && col_q == '0) state_d = RUN;
            RUN: begin
                if (accept && row_q == height_q - ONE && col_q == width_q - ONE) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_step) drain_d = drain_q + ONE;
                if (last_drain) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d  = FILL;
            width_d  = cfg_width;
            height_d = cfg_height;
            bypass_d = bypass;
            bpn_d    = bad_point_num;
            ptr_d    = '0;
            row_d    = '0;
            col_d    = '0;
            orow_d   = '0;
            ocol_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state_q <= IDLE;   width_q <= '0;   height_q <= '0;  bypass_q <= 1'b0;
            bpn_q <= '0;       ptr_q <= '0;     row_q <= '0;     col_q <= '0;
            orow_q <= '0;      ocol_q <= '0;    drain_q <= '0;
            c_top_q <= '0;     c_mid_q <= '0;   c_bot_q <= '0;   l_mid_q <= '0;
            m_valid_q <= 1'b0; m_data_q <= '0;  m_user_q <= 1'b0; m_last_q <= 1'b0;
            frame_done_q <= 1'b0; sof_err_q <= 1'b0; cnt_q <= '0;
        end else begin
            state_q <= state_d;   width_q <= width_d;  height_q <= height_d; bypass_q <= bypass_d;
            bpn_q <= bpn_d;       ptr_q <= ptr_d;      row_q <= row_d;       col_q <= col_d;
            orow_q <= orow_d;     ocol_q <= ocol_d;    drain_q <= drain_d;
            c_top_q <= c_top_d;   c_mid_q <= c_mid_d;  c_bot_q <= c_bot_d;   l_mid_q <= l_mid_d;
            m_valid_q <= m_valid_d; m_data_q <= m_data_d; m_user_q <= m_user_d; m_last_q <= m_last_d;
            frame_done_q <= frame_done_d; sof_err_q <= sof_err_d; cnt_q <= cnt_d;
        end
    end

    // Reads use the next column/pointer so data is ready when the next beat arrives.
    always_ff @(posedge axis_aclk) begin
        if (lut_wen && state_q == IDLE) lut_mem[lut_waddr] <= lut_wdata;
        lut_rd_q <= lut_mem[ptr_d[BAD_BITS-1:0]];
    end

    always_ff @(posedge axis_aclk) begin
        if (accept) begin
            lb1_mem[col_q[COL_AW-1:0]] <= new_pix;
            lb2_mem[col_q[COL_AW-1:0]] <= lb1_rd_q;
        end
        lb1_rd_q <= lb1_mem[col_d[COL_AW-1:0]];
        lb2_rd_q <= lb2_mem[col_d[COL_AW-1:0]];
    end
endmodule

// File: tb/tb_dpc_stream_kernel.sv
// Scoreboard bench for dpc_stream_kernel: directed frames push expected beats,
// an independent monitor pops and compares every accepted output beat.
module tb_dpc_stream_kernel;
    localparam int W = 8, CW = 11, MC = 1024, MB = 128, BB = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, s_tvalid, s_tready, s_tuser, s_tlast;
    logic [W-1:0]  s_tdata, m_tdata;
    logic          m_tvalid, m_tready, m_tuser, m_tlast;
    logic [CW-1:0] cfg_width, cfg_height;
    logic          go, bypass, lut_wen, busy, frame_done, sof_error;
    logic [BB:0]   bad_point_num;
    logic [BB-1:0] lut_waddr;
    logic [2*CW-1:0] lut_wdata;
    logic [15:0]   corrected_cnt;

    dpc_stream_kernel #(.WIDTH(W), .CNT_WIDTH(CW), .MAX_COL(MC), .MAX_BAD(MB), .BAD_BITS(BB)) dut (
        .axis_aclk(clk), .reset(reset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .go(go), .bypass(bypass),
        .bad_point_num(bad_point_num), .lut_wen(lut_wen), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .busy(busy), .frame_done(frame_done), .corrected_cnt(corrected_cnt), .sof_error(sof_error)
    );

    int n_checks = 0, n_fail = 0, fd_cnt = 0;
    logic [W+1:0] exp_q[$];
    logic [W-1:0] in_pix [0:31];
    logic [W-1:0] exp_pix [0:31];
    bit    rand_ready = 1'b0;
    string cur_tag = "reset";

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: compares each transferred beat and checks stability under backpressure.
    initial begin
        logic         hold_v;
        logic [W+1:0] hold_word, w;
        hold_v = 1'b0;
        hold_word = '0;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    check({cur_tag, ":hold_stable"}, {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, hold_word});
                if (m_tvalid && m_tready) begin
                    $display("tb: [%s] out data=%0d user=%0b last=%0b", cur_tag, m_tdata, m_tuser, m_tlast);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL %s:unexpected_output: got data %0d, expected no output", cur_tag, m_tdata);
                    end else begin
                        w = exp_q.pop_front();
                        check({cur_tag, ":out_user_last_data"}, {m_tuser, m_tlast, m_tdata}, w);
                    end
                end
                hold_v = m_tvalid && !m_tready;
                hold_word = {m_tuser, m_tlast, m_tdata};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic lut_write(input int addr, input int row, input int col);
        lut_wen = 1'b1;
        lut_waddr = BB'(addr);
        lut_wdata = {CW'(row), CW'(col)};
        @(posedge clk);
        #1;
        lut_wen = 1'b0;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 32; i++) begin
            in_pix[i] = W'(10 + i);
            exp_pix[i] = W'(10 + i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":m_tvalid"}, m_tvalid, 0);
        check({tag, ":s_tready"}, s_tready, 0);
        check({tag, ":m_tdata_user_last"}, {m_tuser, m_tlast, m_tdata}, 0);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":frame_done"}, frame_done, 0);
        check({tag, ":corrected_cnt"}, corrected_cnt, 0);
        check({tag, ":sof_error"}, sof_error, 0);
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input bit byp, input int bpn,
                             input int sof_idx, input int abort_at, input int exp_cnt);
        int fd_base, k;
        bit acc;
        cur_tag = tag;
        for (int i = 0; i < w * h; i++)
            exp_q.push_back({(i == 0), ((i % w) == w - 1), exp_pix[i]});
        fd_base = fd_cnt;
        cfg_width = CW'(w);
        cfg_height = CW'(h);
        bypass = byp;
        bad_point_num = (BB + 1)'(bpn);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check({tag, ":busy_after_go"}, busy, 1);
        for (int i = 0; i < w * h; i++) begin
            s_tvalid = 1'b1;
            s_tdata = in_pix[i];
            s_tuser = (i == 0) || (i == sof_idx);
            acc = 1'b0;
            k = 0;
            while (!acc && k < 500) begin
                @(negedge clk);
                if (s_tready) begin
                    @(posedge clk);
                    #1;
                    acc = 1'b1;
                end
                k++;
            end
            if (!acc) begin
                check({tag, ":input_accepted"}, 0, 1);
                s_tvalid = 1'b0;
                return;
            end
            $display("tb: [%s] in beat %0d data=%0d", tag, i, in_pix[i]);
            if (i + 1 == abort_at) begin
                s_tvalid = 1'b0;
                s_tuser = 1'b0;
                reset = 1'b1;
                @(posedge clk);
                #1;
                check_reset_outputs({tag, ":midframe"});
                reset = 1'b0;
                exp_q.delete();
                repeat (10) @(posedge clk);
                #1;
                check({tag, ":idle_after_reset"}, busy, 0);
                return;
            end
        end
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        k = 0;
        while (fd_cnt == fd_base && k < 3000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, ":frame_done_count"}, fd_cnt - fd_base, 1);
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({tag, ":outputs_remaining"}, exp_q.size(), 0);
        check({tag, ":corrected_cnt"}, corrected_cnt, exp_cnt);
        check({tag, ":busy_idle"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        cfg_width = '0; cfg_height = '0; go = 1'b0; bypass = 1'b0;
        bad_point_num = '0; lut_wen = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        set_ramp();
        run_frame("plain4x3", 4, 3, 1'b0, 0, -1, 0, 0);

        lut_write(0, 1, 1);
        run_frame("bad11", 4, 3, 1'b0, 1, -1, 0, 1);

        lut_write(1, 1, 2);
        run_frame("bad11_12", 4, 3, 1'b0, 2, -1, 0, 2);

        set_ramp();
        in_pix[0] = 8'd200; in_pix[1] = 8'd50; in_pix[4] = 8'd60;
        exp_pix[0] = 8'd50; exp_pix[1] = 8'd50; exp_pix[4] = 8'd60;
        lut_write(0, 0, 0);
        run_frame("corner", 4, 3, 1'b0, 1, -1, 0, 1);

        exp_pix[0] = 8'd200;
        lut_write(1, 1, 1);
        lut_write(2, 2, 3);
        run_frame("bypass", 4, 3, 1'b1, 3, -1, 0, 0);

        for (int i = 0; i < 32; i++) begin
            in_pix[i] = W'((i * i) & 255);
            exp_pix[i] = W'((i * i) & 255);
        end
        exp_pix[19] = 8'd106;
        exp_pix[31] = 8'd132;
        lut_write(0, 2, 3);
        lut_write(1, 3, 7);
        rand_ready = 1'b1;
        run_frame("stall8x4", 8, 4, 1'b0, 2, -1, 0, 2);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        set_ramp();
        run_frame("abort", 4, 3, 1'b0, 0, -1, 7, 0);
        run_frame("after_reset", 4, 3, 1'b0, 0, -1, 0, 0);

        check("sof_error_clear", sof_error, 0);
        run_frame("sof_err", 4, 3, 1'b0, 0, 5, 0, 0);
        check("sof_error_set", sof_error, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
